tdd_trig_mc: RTL

Multi-channel, parametrised TDD trigger generator for RF-front-end GPIO timing. It arms on a PPS edge when calibration is enabled and computes a first-frame delay from the RX advance and delay settings. It then emits a configurable-width pulse on each enabled channel at a per-channel offset from every 10 ms frame boundary, for one frame, N frames or indefinitely. It sits in harden_sync beside the sync logic and drives the RF GPIO pins.

---
 rtl/tdd_trig_mc_if.sv | 43 ++++
 rtl/tdd_trig_mc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tdd_trig_mc_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tdd_trig_mc_if                                                |
// | Purpose  : Configuration / trigger bundle for the TDD trigger generator. |
// |            The master side drives configuration and PPS. The slave side  |
// |            (tdd_trig_mc) returns the trigger pins and status.            |
// | Signals  : pps_start, calibration_enable, sync_enable, rx_ahead_time,    |
// |            rx_delay_time, burst_count, pulse_width, ch_enable, ch_offset |
// |            (master -> slave); trig_rf_gpio, busy, frame_cnt, cfg_err     |
// |            (slave -> master)                                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface tdd_trig_mc_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) ();
    logic                    pps_start;
    logic                    calibration_enable;
    logic                    sync_enable;
    logic [31:0]             rx_ahead_time;
    logic [31:0]             rx_delay_time;
    logic [15:0]             burst_count;
    logic [7:0]              pulse_width;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH*CNT_W-1:0] ch_offset;
    logic [NUM_CH-1:0]       trig_rf_gpio;
    logic                    busy;
    logic [15:0]             frame_cnt;
    logic                    cfg_err;

    modport master (
        output pps_start, calibration_enable, sync_enable, rx_ahead_time,
               rx_delay_time, burst_count, pulse_width, ch_enable, ch_offset,
        input  trig_rf_gpio, busy, frame_cnt, cfg_err
    );

    modport slave (
        input  pps_start, calibration_enable, sync_enable, rx_ahead_time,
               rx_delay_time, burst_count, pulse_width, ch_enable, ch_offset,
        output trig_rf_gpio, busy, frame_cnt, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/tdd_trig_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tdd_trig_mc                                                   |
// | Purpose  : Multi-channel TDD trigger generator. Arms on a PPS rising     |
// |            edge, waits a computed first-frame delay, then emits one      |
// |            pulse per enabled channel at a per-channel offset inside      |
// |            every frame. It runs for 1 frame, 1+burst_count frames, or    |
// |            until calibration_enable drops.                               |
// | Ports    : clk  - sample clock                                           |
// |            rst  - synchronous active-high reset                          |
// |            bus  - tdd_trig_mc_if.slave (config in, triggers/status out)  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tdd_trig_mc #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int RX_FREQ    = 122880,
    parameter int RF_ADVANCE = 800
) (
    input  logic          clk,
    input  logic          rst,
    tdd_trig_mc_if.slave  bus
);

    // Delay arithmetic is wide enough for both the 32-bit inputs and the
    // counter width, plus a sign bit and an overflow bit.
    localparam int               c_DW       = ((CNT_W > 32) ? CNT_W : 32) + 2;
    localparam logic [CNT_W:0]   c_PERIOD   = (CNT_W+1)'(RX_FREQ * 10);
    localparam logic [CNT_W-1:0] c_PLAST    = CNT_W'(RX_FREQ * 10 - 1);
    localparam logic [c_DW-1:0]  c_PERIOD_D = c_DW'(RX_FREQ * 10);
    localparam logic [c_DW-1:0]  c_ADV_D    = c_DW'(RF_ADVANCE);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    logic [1:0]        r_state;
    logic              r_pps_d;
    logic [CNT_W-1:0]  r_dly;
    logic [CNT_W-1:0]  r_p;
    logic [15:0]       r_fcnt;
    logic [15:0]       r_remain;
    logic              r_unlim;
    logic [NUM_CH-1:0] r_en;
    logic [CNT_W:0]    r_w_ext;
    logic [CNT_W-1:0]  r_off [NUM_CH];
    logic              r_cfg_err;
    logic [NUM_CH-1:0] r_trig;
    logic              r_busy;
    logic [15:0]       r_fcnt_o;

    logic              w_arm;
    logic              w_abort;
    logic [c_DW-1:0]   w_d;
    logic              w_d_err;
    logic [7:0]        w_w_eff;
    logic [CNT_W:0]    w_w_ext;
    logic [CNT_W-1:0]  w_off_in [NUM_CH];
    logic [NUM_CH-1:0] w_off_bad;
    logic [NUM_CH-1:0] w_hit;
    logic [15:0]       w_fcnt_inc;

    assign w_arm   = (r_state == c_ST_IDLE) && bus.pps_start && !r_pps_d
                     && bus.calibration_enable;
    assign w_abort = (r_state != c_ST_IDLE) && !bus.calibration_enable;

    // First-frame delay; negative (sign bit) or >= 2^CNT_W is a config error.
    assign w_d     = c_PERIOD_D - c_DW'(bus.rx_ahead_time)
                     + c_DW'(bus.rx_delay_time) - c_ADV_D;
    assign w_d_err = w_d[c_DW-1] | (|w_d[c_DW-2:CNT_W]);

    assign w_w_eff = (bus.pulse_width == 8'd0) ? 8'd1 : bus.pulse_width;
    assign w_w_ext = (CNT_W+1)'(w_w_eff);

    assign w_fcnt_inc = (r_fcnt == 16'hFFFF) ? r_fcnt : r_fcnt + 16'd1;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_off_in[gi]  = bus.ch_offset[gi*CNT_W +: CNT_W];
            // A pulse must fit inside one frame; one that would straddle the wrap is masked.
            assign w_off_bad[gi] = (({1'b0, w_off_in[gi]} + w_w_ext) > c_PERIOD);
            assign w_hit[gi]     = r_en[gi]
                                   && (r_p >= r_off[gi])
                                   && ({1'b0, r_p} < ({1'b0, r_off[gi]} + r_w_ext));
        end
    endgenerate

    // Control path: arm, first-delay count, phase counter, frame accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_pps_d   <= 1'b0;
            r_dly     <= '0;
            r_p       <= '0;
            r_fcnt    <= '0;
            r_remain  <= '0;
            r_unlim   <= 1'b0;
            r_en      <= '0;
            r_w_ext   <= '0;
            r_cfg_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_off[i] <= '0;
        end else begin
            // Edge history runs in every state so a level held across busy never arms.
            r_pps_d <= bus.pps_start;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_arm) begin
                        r_en      <= bus.ch_enable & ~w_off_bad;
                        r_w_ext   <= w_w_ext;
                        for (int i = 0; i < NUM_CH; i++) r_off[i] <= w_off_in[i];
                        r_unlim   <= !bus.sync_enable && (bus.burst_count == 16'd0);
                        r_remain  <= bus.sync_enable ? 16'd0 : bus.burst_count;
                        r_cfg_err <= w_d_err | (|w_off_bad);
                        r_p       <= '0;
                        r_dly     <= w_d[CNT_W-1:0];
                        if (w_d_err) begin
                            r_fcnt <= 16'd0;
                        end else if (w_d[CNT_W-1:0] == '0) begin
                            // Zero delay: the arm edge itself is the first boundary.
                            r_fcnt  <= 16'd1;
                            r_state <= c_ST_RUN;
                        end else begin
                            r_fcnt  <= 16'd0;
                            r_state <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (w_abort) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_dly == CNT_W'(1)) begin
                        r_state <= c_ST_RUN;
                        r_p     <= '0;
                        r_fcnt  <= w_fcnt_inc;
                    end else begin
                        r_dly <= r_dly - CNT_W'(1);
                    end
                end
                c_ST_RUN: begin
                    if (w_abort) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_p == c_PLAST) begin
                        r_p <= '0;
                        if (!r_unlim && (r_remain == 16'd0)) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_fcnt <= w_fcnt_inc;
                            if (!r_unlim) r_remain <= r_remain - 16'd1;
                        end
                    end else begin
                        r_p <= r_p + CNT_W'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Output register stage. An abort clears the pins on the same edge that
    // sees calibration_enable low, so nothing from the lagging stage leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig   <= '0;
            r_busy   <= 1'b0;
            r_fcnt_o <= '0;
        end else begin
            r_fcnt_o <= r_fcnt;
            if (w_abort) begin
                r_trig <= '0;
                r_busy <= 1'b0;
            end else begin
                r_trig <= (r_state == c_ST_RUN) ? w_hit : '0;
                r_busy <= (r_state != c_ST_IDLE);
            end
        end
    end

    assign bus.trig_rf_gpio = r_trig;
    assign bus.busy         = r_busy;
    assign bus.frame_cnt    = r_fcnt_o;
    assign bus.cfg_err      = r_cfg_err;

endmodule
`default_nettype wire
